// File: rtl/deser_pkg.sv
// Shared types and helpers for the multi-width serial-to-parallel deserializer.
// The FSM state encoding doubles as the EA_des debug value.
package deser_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        RECEIVE = 2'd1,
        PARITY  = 2'd2,
        FULL    = 2'd3
    } state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_MAX_WIDTH = 256;

    function automatic logic parity_ok(
        input logic [PARITY_MAX_WIDTH-1:0] word,
        input logic                        par_bit,
        input logic                        odd
    );
        return (((^word) ^ par_bit) == odd);
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// Completed-word buffer: circular FIFO with registered head, non-empty flag and level.
// The head register is loaded with the word that will be at the front after each edge.
module deser_word_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 2,
    localparam int LW        = $clog2(OUT_DEPTH + 1)
) (
    input  logic                  clock_100KHZ,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  not_empty,
    output logic [LW-1:0]         level
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [OUT_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         rd_ptr_next_s;
    logic [LW-1:0]         level_r;
    logic [LW-1:0]         level_next_s;
    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] head_next_s;
    logic                  not_empty_r;
    logic                  pop_en_s;
    logic                  push_en_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(OUT_DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign pop_en_s  = pop && (level_r != LW'(0));
    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign push_en_s = push && ((level_r != LW'(OUT_DEPTH)) || pop_en_s);

    // Next level, next read pointer and next head word.
    always_comb begin
        level_next_s  = level_r;
        rd_ptr_next_s = rd_ptr_r;
        head_next_s   = '0;
        if (push_en_s && !pop_en_s) begin
            level_next_s = level_r + LW'(1);
        end else if (!push_en_s && pop_en_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
        if (pop_en_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (level_next_s == LW'(0)) begin
            head_next_s = '0;
        end else if (push_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage, pointers and registered outputs.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            head_r      <= '0;
            not_empty_r <= 1'b0;
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            head_r      <= head_next_s;
            not_empty_r <= (level_next_s != LW'(0));
        end
    end

    assign head      = head_r;
    assign not_empty = not_empty_r;
    assign level     = level_r;

endmodule

// File: rtl/deserializer_multi.sv
// Parametrised serial-to-parallel deserializer: FSM, shift register and parity check,
// feeding completed words into a small FIFO that talks the data_ready/ack_in handshake.
module deserializer_multi
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                             clock_100KHZ,
    input  logic                             reset,
    input  logic                             data_in,
    input  logic                             write_in,
    input  logic                             abort_in,
    input  logic                             ack_in,
    output logic                             status_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_ready,
    output logic                             parity_err,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   buf_level,
    output logic [1:0]                       EA_des
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int LW = $clog2(OUT_DEPTH + 1);

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_next_s;
    logic                  status_r;
    logic                  parity_err_r;
    logic                  parity_err_next_s;
    logic                  push_s;
    logic [DATA_WIDTH-1:0] push_word_s;
    logic                  accept_s;
    logic                  pop_eff_s;
    logic                  fills_s;
    logic [LW-1:0]         level_s;

    assign accept_s  = status_r && write_in;
    assign pop_eff_s = ack_in && (level_s != LW'(0));
    // A push without a pop that occupies the last free slot stops reception.
    assign fills_s   = !pop_eff_s && (level_s == LW'(OUT_DEPTH - 1));

    // Shift register contents if the current data_in bit were taken.
    always_comb begin
        shifted_s = shift_r;
        if (MSB_FIRST != 0) begin
            shifted_s = {shift_r[DATA_WIDTH-2:0], data_in};
        end else begin
            shifted_s = {data_in, shift_r[DATA_WIDTH-1:1]};
        end
    end

    // Next-state, datapath and push decisions; abort wins over any bit on the same edge.
    always_comb begin
        state_next_s      = state_r;
        shift_next_s      = shift_r;
        cnt_next_s        = cnt_r;
        push_s            = 1'b0;
        push_word_s       = shifted_s;
        parity_err_next_s = 1'b0;
        case (state_r)
            SYNC: begin
                state_next_s = RECEIVE;
            end
            RECEIVE: begin
                if (abort_in) begin
                    shift_next_s = '0;
                    cnt_next_s   = '0;
                end else if (accept_s && (cnt_r == CW'(DATA_WIDTH - 1))) begin
                    if (PARITY_EN != 0) begin
                        shift_next_s = shifted_s;
                        cnt_next_s   = CW'(DATA_WIDTH);
                        state_next_s = PARITY;
                    end else begin
                        push_s       = 1'b1;
                        push_word_s  = shifted_s;
                        shift_next_s = '0;
                        cnt_next_s   = '0;
                        if (fills_s) begin
                            state_next_s = FULL;
                        end else begin
                            state_next_s = RECEIVE;
                        end
                    end
                end else if (accept_s) begin
                    shift_next_s = shifted_s;
                    cnt_next_s   = cnt_r + CW'(1);
                end else begin
                    state_next_s = RECEIVE;
                end
            end
            PARITY: begin
                if (abort_in) begin
                    shift_next_s = '0;
                    cnt_next_s   = '0;
                    state_next_s = RECEIVE;
                end else if (accept_s) begin
                    shift_next_s = '0;
                    cnt_next_s   = '0;
                    if (parity_ok(PARITY_MAX_WIDTH'(shift_r), data_in, (PARITY_ODD != 0))) begin
                        push_s      = 1'b1;
                        push_word_s = shift_r;
                        if (fills_s) begin
                            state_next_s = FULL;
                        end else begin
                            state_next_s = RECEIVE;
                        end
                    end else begin
                        parity_err_next_s = 1'b1;
                        state_next_s      = RECEIVE;
                    end
                end else begin
                    state_next_s = PARITY;
                end
            end
            FULL: begin
                if (pop_eff_s) begin
                    state_next_s = RECEIVE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = SYNC;
                shift_next_s = '0;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, shift register, counter and registered status flags.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state_r      <= SYNC;
            shift_r      <= '0;
            cnt_r        <= '0;
            status_r     <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            shift_r      <= shift_next_s;
            cnt_r        <= cnt_next_s;
            status_r     <= (state_next_s == RECEIVE) || (state_next_s == PARITY);
            parity_err_r <= parity_err_next_s;
        end
    end

    deser_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_DEPTH  (OUT_DEPTH)
    ) u_fifo (
        .clock_100KHZ (clock_100KHZ),
        .reset        (reset),
        .push         (push_s),
        .push_data    (push_word_s),
        .pop          (ack_in),
        .head         (data_out),
        .not_empty    (data_ready),
        .level        (level_s)
    );

    assign buf_level  = level_s;
    assign status_out = status_r;
    assign parity_err = parity_err_r;
    assign EA_des     = state_r;

endmodule

// File: doc/deserializer_multi.md
Name: deserializer_multi

Overview:
- Parametrised successor of the team's 1-bit serial-to-parallel deserializer in the 100 kHz domain.
- Assembles DATA_WIDTH-bit words from a bit stream qualified by write_in, with selectable bit order and an optional parity bit.
- Buffers up to OUT_DEPTH completed words, so reception continues while the downstream queue has not yet acked.
- Sits between the serial stimulus source and the queue, using the existing data_ready/ack_in handshake.

Parameters:
- DATA_WIDTH, 8: bits per word, minimum 2.
- MSB_FIRST, 1: 1 = first received bit lands in the MSB; 0 = first received bit lands in the LSB.
- PARITY_EN, 0: 1 = one parity bit follows each word.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- OUT_DEPTH, 2: completed-word buffer depth, minimum 1.

Ports:
- clock_100KHZ  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- data_in  input  1  serial data bit.
- write_in  input  1  data_in valid this cycle.
- abort_in  input  1  discard the partial word.
- ack_in  input  1  queue consumed the head word.
- status_out  output  1  1 = accepting bits.
- data_out  output  DATA_WIDTH  head word of the buffer.
- data_ready  output  1  buffer non-empty.
- parity_err  output  1  one-cycle pulse when a word is dropped for bad parity.
- buf_level  output  $clog2(OUT_DEPTH+1)  number of words held.
- EA_des  output  2  current state, for debug.

Behaviour:
- Reset (asynchronous):
  - status_out = 0, data_ready = 0, data_out = 0, parity_err = 0, buf_level = 0.
  - Shift register and bit counter cleared; state = SYNC.
- States and EA_des encoding: SYNC = 0, RECEIVE = 1, PARITY = 2, FULL = 3.
- SYNC: held for exactly one cycle after reset release, with status_out = 0, then goes to RECEIVE.
- status_out: registered; 1 in RECEIVE and PARITY, 0 in SYNC and FULL.
- Bit acceptance:
  - A bit is sampled only on a clock edge where status_out = 1 and write_in = 1.
  - write_in while status_out = 0 is ignored; no bit is lost silently beyond that.
- Bit order:
  - MSB_FIRST = 1: shift left, new bit enters bit 0.
  - MSB_FIRST = 0: shift right, new bit enters bit DATA_WIDTH-1.
- Word completion:
  - On the edge sampling bit DATA_WIDTH:
    - PARITY_EN = 0: push the word immediately.
    - PARITY_EN = 1: go to PARITY and wait for one more write_in bit.
  - Parity check, on the parity edge: XOR(word bits, parity bit) must equal PARITY_ODD.
    - Pass: push the word.
    - Fail: discard the word, parity_err = 1 for one cycle, buffer unchanged.
  - The bit counter returns to 0 after every completed or discarded word.
- Push latency:
  - A word pushed at edge N is visible on data_out and data_ready after edge N when the buffer was empty.
  - Otherwise it queues behind earlier words in FIFO order.
- Handshake:
  - data_ready = (buf_level != 0).
  - data_out always shows the head word; 0 when empty.
  - ack_in while data_ready = 1 pops the head at that edge.
  - ack_in while empty is ignored.
  - Holding ack_in high pops one word per cycle.
- Full:
  - If a push makes buf_level = OUT_DEPTH, go to FULL; status_out = 0 from the next cycle.
  - FULL → RECEIVE on the edge that pops; status_out = 1 the following cycle.
- Simultaneous push and pop on the same edge: both happen; buf_level is unchanged; no transition to FULL.
- abort_in:
  - Clears the partial shift register and bit counter; PARITY → RECEIVE.
  - Buffer contents are kept.
  - abort_in takes priority over a bit sampled on the same edge, including the last data bit or the parity bit.
  - No effect in SYNC or FULL.
- Reset mid-word or mid-buffer: everything is discarded; behaviour resumes from SYNC.
- Widths:
  - Bit counter is $clog2(DATA_WIDTH+1) bits.
  - Buffer pointers are $clog2(OUT_DEPTH) bits, minimum 1, and wrap modulo OUT_DEPTH.

Decomposition:
- Package deser_pkg:
  - state_t enum {SYNC, RECEIVE, PARITY, FULL}, explicitly encoded 0-3.
  - Function parity_ok(word, bit, odd).
- Sub-module deser_word_fifo: DATA_WIDTH × OUT_DEPTH buffer with push/pop, head output and level counter.
- Top level: FSM, shift register and parity check.

Test Plan:
- Defaults (8-bit, MSB first, no parity).
  - Send bits 1,0,1,1,0,0,1,0 → data_out = 8'hB2 and data_ready = 1 after the 8th edge.
  - ack_in for 1 cycle → data_ready = 0 and data_out = 0 next cycle.
- MSB_FIRST = 0: send the same bits → data_out = 8'h4D.
- PARITY_EN = 1, PARITY_ODD = 0:
  - Send 8'hB2 with parity bit 0 → word accepted.
  - Send 8'hB2 with parity bit 1 → parity_err pulses for 1 cycle, data_ready stays 0, buf_level = 0.
- OUT_DEPTH = 2, no ack:
  - Send 8'h11 then 8'h22 → buf_level = 2, status_out = 0, EA_des = 3.
  - A 3rd word's bits are ignored.
  - ack_in → data_out = 8'h22, status_out = 1 one cycle later.
- Abort and simultaneous events:
  - Send 3 bits, pulse abort_in, then send 8'hA5 → data_out = 8'hA5.
  - Completing a word on the same edge as ack_in with buf_level = 1 → buf_level stays 1 and shows the new word.
- Reset mid-word:
  - Assert reset after 5 bits → all outputs 0, EA_des = 0.
  - After release, status_out = 0 for 1 cycle, then 1.
  - A full 8-bit word then decodes correctly.
